algo_2r2w_rdq: RTL and testbench

//  Per-port read-response queue directly downstream of the 2R2W memory top wrapper.

---
 rtl/algo_rdq_pkg.sv | 20 ++
 rtl/algo_rdq_fifo.sv | 65 ++++++
 rtl/algo_2r2w_rdq.sv | 135 +++++++++++++
 tb/tb_algo_2r2w_rdq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/algo_rdq_pkg.sv
// Shared definitions for the 2R2W read-response queue: counter widths and error-flag layout.
package algo_rdq_pkg;

  // Default queue depth; the matching counter type is provided for integrators.
  localparam int unsigned RDQ_DEF_DEPTH = 4;
  localparam int unsigned RDQ_CNT_W     = $clog2(RDQ_DEF_DEPTH) + 1;

  // Bit positions inside the sticky error-flag vector.
  localparam int unsigned ERR_OVF_BIT = 0;
  localparam int unsigned ERR_SEQ_BIT = 1;
  localparam int unsigned ERR_NUM     = 2;

  typedef logic [RDQ_CNT_W-1:0] rdq_cnt_t;

  // Credit/count width: must be able to hold the value DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return int'($clog2(depth)) + 1;
  endfunction

endpackage

// File: rtl/algo_rdq_fifo.sv
// One-port synchronous FIFO with a combinational head read and no push-to-pop bypass.
module algo_rdq_fifo
  import algo_rdq_pkg::*;
#(
  parameter int unsigned WIDTH    = 15,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned BITDEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          full
);

  localparam int unsigned CNTW = cnt_width(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [BITDEPTH-1:0] wptr;
  logic [BITDEPTH-1:0] rptr;
  logic                empty;
  logic                pop_en;
  logic                push_en;

  // Occupancy flags; a full queue still accepts a push when it pops in the same cycle.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CNTW'(DEPTH));
    pop_en  = pop & ~empty;
    push_en = push & (~full | pop_en);
    dout    = mem[rptr];
  end

  // Pointers and count; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_en) begin
        wptr <= (wptr == BITDEPTH'(DEPTH - 1)) ? '0 : wptr + BITDEPTH'(1);
      end
      if (pop_en) begin
        rptr <= (rptr == BITDEPTH'(DEPTH - 1)) ? '0 : rptr + BITDEPTH'(1);
      end
      if (push_en && !pop_en) begin
        count <= count + CNTW'(1);
      end else if (pop_en && !push_en) begin
        count <= count - CNTW'(1);
      end
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wptr] <= din;
    end
  end

endmodule

// File: rtl/algo_2r2w_rdq.sv
// Per-port read-response queue: credit-gated request forwarding, return tracking and output FIFOs.
module algo_2r2w_rdq
  import algo_rdq_pkg::*;
#(
  parameter int unsigned NUMRDPRT = 2,
  parameter int unsigned WIDTH    = 15,
  parameter int unsigned BITADDR  = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned BITDEPTH = 2,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUMRDPRT-1:0]         req_read,
  input  logic [NUMRDPRT*BITADDR-1:0] req_adr,
  output logic [NUMRDPRT-1:0]         req_rdy,
  output logic [NUMRDPRT-1:0]         read,
  output logic [NUMRDPRT*BITADDR-1:0] rd_adr,
  input  logic [NUMRDPRT-1:0]         rd_vld,
  input  logic [NUMRDPRT*WIDTH-1:0]   rd_dout,
  output logic [NUMRDPRT-1:0]         out_vld,
  output logic [NUMRDPRT*WIDTH-1:0]   out_dout,
  input  logic [NUMRDPRT-1:0]         out_rdy,
  output logic                        err_ovf,
  output logic                        err_seq
);

  localparam int unsigned CNTW = cnt_width(DEPTH);

  logic [CNTW-1:0]     cred     [NUMRDPRT];
  logic [CNTW-1:0]     cred_nxt [NUMRDPRT];
  logic [CNTW-1:0]     fifo_cnt [NUMRDPRT];
  logic [NUMRDPRT-1:0] fifo_full;
  logic [NUMRDPRT-1:0] acc;
  logic [NUMRDPRT-1:0] pop;
  logic [NUMRDPRT-1:0] exp_ret;
  logic [ERR_NUM-1:0]  err_q;
  logic                ovf_any;
  logic                seq_any;

  // Request path: accept only with a free credit, forward straight to the wrapper.
  assign acc    = req_read & req_rdy;
  assign read   = acc;
  assign rd_adr = req_adr;
  assign pop    = out_vld & out_rdy;

  // Per-port queue and credit-ready decode.
  for (genvar p = 0; p < NUMRDPRT; p++) begin : g_port
    assign req_rdy[p] = (cred[p] != '0);
    assign out_vld[p] = (fifo_cnt[p] != '0);

    algo_rdq_fifo #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .BITDEPTH (BITDEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rd_vld[p]),
      .pop   (out_rdy[p]),
      .din   (rd_dout[p*WIDTH +: WIDTH]),
      .dout  (out_dout[p*WIDTH +: WIDTH]),
      .count (fifo_cnt[p]),
      .full  (fifo_full[p])
    );
  end

  // Credit next-state: accept consumes, pop returns, saturating at 0 and DEPTH.
  always_comb begin
    for (int p = 0; p < NUMRDPRT; p++) begin
      cred_nxt[p] = cred[p];
      if (acc[p] && !pop[p]) begin
        cred_nxt[p] = cred[p] - CNTW'(1);
      end else if (pop[p] && !acc[p] && (cred[p] < CNTW'(DEPTH))) begin
        cred_nxt[p] = cred[p] + CNTW'(1);
      end
    end
  end

  // Credit registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NUMRDPRT; p++) begin
        cred[p] <= CNTW'(DEPTH);
      end
    end else begin
      for (int p = 0; p < NUMRDPRT; p++) begin
        cred[p] <= cred_nxt[p];
      end
    end
  end

  // Expected-return tracking: accepts delayed by the wrapper read latency.
  if (RD_LAT == 0) begin : g_exp_comb
    assign exp_ret = acc;
  end else begin : g_exp_sr
    logic [NUMRDPRT-1:0] exp_sr [RD_LAT];

    // Shift register of accepted requests still in flight.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < int'(RD_LAT); i++) begin
          exp_sr[i] <= '0;
        end
      end else begin
        exp_sr[0] <= acc;
        for (int i = 1; i < int'(RD_LAT); i++) begin
          exp_sr[i] <= exp_sr[i-1];
        end
      end
    end

    assign exp_ret = exp_sr[RD_LAT-1];
  end

  // Error detection: overflow is a drop-causing push, sequence is any return mismatch.
  always_comb begin
    ovf_any = |(rd_vld & fifo_full & ~pop);
    seq_any = |(rd_vld ^ exp_ret);
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
    end else begin
      err_q[ERR_OVF_BIT] <= err_q[ERR_OVF_BIT] | ovf_any;
      err_q[ERR_SEQ_BIT] <= err_q[ERR_SEQ_BIT] | seq_any;
    end
  end

  assign err_ovf = err_q[ERR_OVF_BIT];
  assign err_seq = err_q[ERR_SEQ_BIT];

endmodule

// File: tb/tb_algo_2r2w_rdq.sv
// Directed self-checking bench for the 2R2W read-response queue.
module tb_algo_2r2w_rdq;

  localparam int unsigned NUMRDPRT = 2;
  localparam int unsigned WIDTH    = 15;
  localparam int unsigned BITADDR  = 8;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned BITDEPTH = 2;
  localparam int unsigned RD_LAT   = 1;

  logic                        clk;
  logic                        rst;
  logic [NUMRDPRT-1:0]         req_read;
  logic [NUMRDPRT*BITADDR-1:0] req_adr;
  logic [NUMRDPRT-1:0]         req_rdy;
  logic [NUMRDPRT-1:0]         read;
  logic [NUMRDPRT*BITADDR-1:0] rd_adr;
  logic [NUMRDPRT-1:0]         rd_vld;
  logic [NUMRDPRT*WIDTH-1:0]   rd_dout;
  logic [NUMRDPRT-1:0]         out_vld;
  logic [NUMRDPRT*WIDTH-1:0]   out_dout;
  logic [NUMRDPRT-1:0]         out_rdy;
  logic                        err_ovf;
  logic                        err_seq;

  int checks = 0;
  int errors = 0;

  algo_2r2w_rdq #(
    .NUMRDPRT (NUMRDPRT),
    .WIDTH    (WIDTH),
    .BITADDR  (BITADDR),
    .DEPTH    (DEPTH),
    .BITDEPTH (BITDEPTH),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_read (req_read),
    .req_adr  (req_adr),
    .req_rdy  (req_rdy),
    .read     (read),
    .rd_adr   (rd_adr),
    .rd_vld   (rd_vld),
    .rd_dout  (rd_dout),
    .out_vld  (out_vld),
    .out_dout (out_dout),
    .out_rdy  (out_rdy),
    .err_ovf  (err_ovf),
    .err_seq  (err_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_read = '0;
    req_adr  = '0;
    rd_vld   = '0;
    rd_dout  = '0;
    out_rdy  = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req_rdy !== 2'b11) begin errors++; $display("FAIL reset_req_rdy: got %b want 11", req_rdy); end
    checks++;
    if (out_vld !== 2'b00) begin errors++; $display("FAIL reset_out_vld: got %b want 00", out_vld); end
    checks++;
    if (err_ovf !== 1'b0 || err_seq !== 1'b0) begin
      errors++; $display("FAIL reset_err: got ovf=%b seq=%b want 0 0", err_ovf, err_seq);
    end
    checks++;
    if (dut.cred[0] !== 3'd4 || dut.cred[1] !== 3'd4) begin
      errors++; $display("FAIL reset_cred: got %0d %0d want 4 4", dut.cred[0], dut.cred[1]);
    end
  endtask

  task automatic test_single_read();
    req_read = 2'b01;
    req_adr[7:0] = 8'h12;
    #1;
    checks++;
    if (read !== 2'b01 || rd_adr[7:0] !== 8'h12) begin
      errors++; $display("FAIL single_fwd: got read=%b adr=%h want 01 12", read, rd_adr[7:0]);
    end
    tick();
    req_read = 2'b00;
    checks++;
    if (dut.cred[0] !== 3'd3) begin errors++; $display("FAIL single_cred_dec: got %0d want 3", dut.cred[0]); end
    rd_vld = 2'b01;
    rd_dout[14:0] = 15'h1ABC;
    #1;
    checks++;
    if (out_vld[0] !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b want 0", out_vld[0]); end
    tick();
    rd_vld = 2'b00;
    #1;
    checks++;
    if (out_vld[0] !== 1'b1 || out_dout[14:0] !== 15'h1ABC) begin
      errors++; $display("FAIL single_data: got vld=%b dout=%h want 1 1abc", out_vld[0], out_dout[14:0]);
    end
    checks++;
    if (err_seq !== 1'b0) begin errors++; $display("FAIL single_seq: got %b want 0", err_seq); end
    out_rdy = 2'b01;
    tick();
    out_rdy = 2'b00;
    checks++;
    if (out_vld[0] !== 1'b0 || dut.cred[0] !== 3'd4) begin
      errors++; $display("FAIL single_pop: got vld=%b cred=%0d want 0 4", out_vld[0], dut.cred[0]);
    end
  endtask

  task automatic test_credit_exhaust();
    out_rdy = 2'b00;
    for (int i = 0; i < 5; i++) begin
      req_read = 2'b10;
      req_adr[15:8] = 8'h40 + 8'(i);
      rd_vld = (i > 0) ? 2'b10 : 2'b00;
      rd_dout[29:15] = 15'h100 + 15'(i - 1);
      #1;
      checks++;
      if (i < 4) begin
        if (read[1] !== 1'b1) begin errors++; $display("FAIL exhaust_accept%0d: got read=%b want 1", i, read[1]); end
      end else begin
        if (read[1] !== 1'b0 || req_rdy[1] !== 1'b0) begin
          errors++; $display("FAIL exhaust_block: got read=%b rdy=%b want 0 0", read[1], req_rdy[1]);
        end
      end
      tick();
    end
    req_read = 2'b00;
    rd_vld = 2'b00;
    #1;
    checks++;
    if (out_vld[1] !== 1'b1 || out_dout[29:15] !== 15'h100 || dut.cred[1] !== 3'd0) begin
      errors++; $display("FAIL exhaust_state: got vld=%b head=%h cred=%0d want 1 100 0",
                         out_vld[1], out_dout[29:15], dut.cred[1]);
    end
    checks++;
    if (err_seq !== 1'b0 || err_ovf !== 1'b0) begin
      errors++; $display("FAIL exhaust_err: got seq=%b ovf=%b want 0 0", err_seq, err_ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] head_exp;
    bit drained;
    for (int k = 0; k < 7; k++) begin
      req_read = 2'b10;
      out_rdy  = 2'b10;
      rd_vld   = (k >= 2) ? 2'b10 : 2'b00;
      rd_dout[29:15] = 15'h200 + 15'(k);
      head_exp = (k < 4) ? 15'h100 + 15'(k) : 15'h200 + 15'(k - 2);
      #1;
      checks++;
      if (k == 0) begin
        if (req_rdy[1] !== 1'b0 || read[1] !== 1'b0) begin
          errors++; $display("FAIL b2b_full_rdy: got rdy=%b read=%b want 0 0", req_rdy[1], read[1]);
        end
      end else begin
        if (req_rdy[1] !== 1'b1 || read[1] !== 1'b1) begin
          errors++; $display("FAIL b2b_rdy%0d: got rdy=%b read=%b want 1 1", k, req_rdy[1], read[1]);
        end
      end
      checks++;
      if (out_vld[1] !== 1'b1 || out_dout[29:15] !== head_exp) begin
        errors++; $display("FAIL b2b_head%0d: got vld=%b head=%h want 1 %h", k, out_vld[1], out_dout[29:15], head_exp);
      end
      tick();
    end
    req_read = 2'b00;
    out_rdy  = 2'b00;
    rd_vld   = 2'b10;
    rd_dout[29:15] = 15'h207;
    tick();
    rd_vld = 2'b00;
    checks++;
    if (err_ovf !== 1'b0 || err_seq !== 1'b0) begin
      errors++; $display("FAIL b2b_err: got ovf=%b seq=%b want 0 0", err_ovf, err_seq);
    end
    out_rdy = 2'b10;
    drained = 1'b0;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (out_vld[1] === 1'b0) begin
        drained = 1'b1;
        break;
      end
    end
    out_rdy = 2'b00;
    checks++;
    if (!drained || dut.cred[1] !== 3'd4) begin
      errors++; $display("FAIL b2b_drain: got drained=%b cred=%0d want 1 4", drained, dut.cred[1]);
    end
  endtask

  task automatic test_unexpected_return();
    rd_vld = 2'b01;
    rd_dout[14:0] = 15'h0AAA;
    tick();
    rd_vld = 2'b00;
    checks++;
    if (err_seq !== 1'b1) begin errors++; $display("FAIL seq_set: got %b want 1", err_seq); end
    checks++;
    if (out_vld[0] !== 1'b1 || out_dout[14:0] !== 15'h0AAA) begin
      errors++; $display("FAIL seq_pushed: got vld=%b dout=%h want 1 0aaa", out_vld[0], out_dout[14:0]);
    end
    repeat (3) tick();
    checks++;
    if (err_seq !== 1'b1) begin errors++; $display("FAIL seq_sticky: got %b want 1", err_seq); end
    out_rdy = 2'b01;
    tick();
    out_rdy = 2'b00;
    checks++;
    if (dut.cred[0] !== 3'd4 || out_vld[0] !== 1'b0) begin
      errors++; $display("FAIL seq_cred_sat: got cred=%0d vld=%b want 4 0", dut.cred[0], out_vld[0]);
    end
  endtask

  task automatic test_overflow();
    out_rdy = 2'b00;
    for (int i = 0; i < 5; i++) begin
      rd_vld = 2'b01;
      rd_dout[14:0] = 15'h300 + 15'(i);
      tick();
      if (i == 3) begin
        checks++;
        if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", err_ovf); end
      end
    end
    rd_vld = 2'b00;
    #1;
    checks++;
    if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", err_ovf); end
    checks++;
    if (out_vld[0] !== 1'b1 || out_dout[14:0] !== 15'h300) begin
      errors++; $display("FAIL ovf_head: got vld=%b dout=%h want 1 300", out_vld[0], out_dout[14:0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req_read = (c < 3) ? 2'b01 : 2'b00;
      req_adr[7:0] = 8'h50 + 8'(c);
      rd_vld = (c > 0) ? 2'b01 : 2'b00;
      rd_dout[14:0] = 15'h400 + 15'(c);
      tick();
    end
    req_read = 2'b00;
    rd_vld = 2'b00;
    #1;
    checks++;
    if (out_vld[0] !== 1'b1 || dut.cred[0] !== 3'd1 || dut.g_port[0].u_fifo.count !== 3'd3) begin
      errors++; $display("FAIL mid_pre: got vld=%b cred=%0d cnt=%0d want 1 1 3",
                         out_vld[0], dut.cred[0], dut.g_port[0].u_fifo.count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (out_vld !== 2'b00 || req_rdy !== 2'b11) begin
      errors++; $display("FAIL mid_async: got vld=%b rdy=%b want 00 11", out_vld, req_rdy);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (dut.cred[0] !== 3'd4 || dut.g_port[0].u_fifo.wptr !== 2'd0 || dut.g_port[0].u_fifo.rptr !== 2'd0) begin
      errors++; $display("FAIL mid_release: got cred=%0d wptr=%0d rptr=%0d want 4 0 0",
                         dut.cred[0], dut.g_port[0].u_fifo.wptr, dut.g_port[0].u_fifo.rptr);
    end
    checks++;
    if (err_ovf !== 1'b0 || err_seq !== 1'b0 || out_vld !== 2'b00) begin
      errors++; $display("FAIL mid_clear: got ovf=%b seq=%b vld=%b want 0 0 00", err_ovf, err_seq, out_vld);
    end
  endtask

  initial begin
    rst = 1'b0;
    req_read = '0;
    req_adr  = '0;
    rd_vld   = '0;
    rd_dout  = '0;
    out_rdy  = '0;
    test_reset();
    test_single_read();
    test_credit_exhaust();
    test_back_to_back();
    test_unexpected_return();
    test_overflow();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
